// File: rtl/dvi_timing_pkg.sv
// Shared constants for the DVI timing generator: default 640x480@60 timing,
// counter/pixel widths and the eight colour-bar values.
package dvi_timing_pkg;

    localparam int CNT_W = 12;
    localparam int RGB_W = 24;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_timing_gen_if.sv
// Video-side bundle of the DVI timing generator: pixel request towards the
// frame buffer, returned RGB, and the sync/data outputs towards the encoders.
interface dvi_timing_gen_if;
    import dvi_timing_pkg::*;

    logic [RGB_W-1:0] rgb_in;
    logic             pix_req;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             vde;
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] rgb_out;
    logic             sof;

    modport master (
        input  rgb_in,
        output pix_req, pix_x, pix_y, vde, hsync, vsync, rgb_out, sof
    );

    modport slave (
        output rgb_in,
        input  pix_req, pix_x, pix_y, vde, hsync, vsync, rgb_out, sof
    );

endinterface

// File: rtl/dvi_colorbar.sv
// Eight vertical colour bars, one cycle behind the pixel request like a frame
// buffer read. Only compiled when DVI_TIMING_COLORBAR_EN is defined.
`ifdef DVI_TIMING_COLORBAR_EN
module dvi_colorbar
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [CNT_W-1:0] x,
    output logic [RGB_W-1:0] rgb
);

    localparam int               BAR_W    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0] pos;
    logic [2:0]       idx;
    logic [CNT_W-1:0] pos_c;
    logic [2:0]       idx_c;

    // Column 0 restarts the bar walk so no divider on x is needed.
    always_comb begin
        pos_c = pos;
        idx_c = idx;
        if (x == '0) begin
            pos_c = '0;
            idx_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
            idx <= '0;
            rgb <= '0;
        end else begin
            rgb <= req ? bar_color(idx_c) : '0;
            if (req) begin
                if (pos_c == BAR_LAST) begin
                    pos <= '0;
                    idx <= idx_c + 3'd1;
                end else begin
                    pos <= pos_c + 1'b1;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/dvi_timing_gen.sv
// DVI video timing generator: raster counters, pixel request two cycles ahead
// of vde, and registered sync/data. DVI_TIMING_COLORBAR_EN selects bar pattern.
module dvi_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic          pix_clk,
    input  logic          rst,
    dvi_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active_c, hs_c, vs_c, sof_c;
    logic             req_p0, hs_p0, vs_p0, sof_p0;
    logic [CNT_W-1:0] x_p0, y_p0;
    logic             req_p1, hs_p1, vs_p1, sof_p1;
    logic             vde_p2, hs_p2, vs_p2, sof_p2;
    logic [RGB_W-1:0] rgb_p2;
    logic [RGB_W-1:0] rgb_src;

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active_c = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_c     = (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    assign vs_c     = (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
    assign sof_c    = active_c && (h_cnt == '0) && (v_cnt == '0);

`ifdef DVI_TIMING_COLORBAR_EN
    logic [RGB_W-1:0] bar_rgb;

    dvi_colorbar #(.H_ACTIVE(H_ACTIVE)) u_colorbar (
        .clk (pix_clk),
        .rst (rst),
        .req (req_p0),
        .x   (x_p0),
        .rgb (bar_rgb)
    );

    assign rgb_src = bar_rgb;
`else
    assign rgb_src = vid.rgb_in;
`endif

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            req_p0 <= 1'b0;
            x_p0   <= '0;
            y_p0   <= '0;
            hs_p0  <= ~HS_POL;
            vs_p0  <= ~VS_POL;
            sof_p0 <= 1'b0;
            req_p1 <= 1'b0;
            hs_p1  <= ~HS_POL;
            vs_p1  <= ~VS_POL;
            sof_p1 <= 1'b0;
            vde_p2 <= 1'b0;
            hs_p2  <= ~HS_POL;
            vs_p2  <= ~VS_POL;
            sof_p2 <= 1'b0;
            rgb_p2 <= '0;
        end else begin
            // p0: request and coordinates, sync decoded from the counters
            req_p0 <= active_c;
            x_p0   <= active_c ? h_cnt : '0;
            y_p0   <= active_c ? v_cnt : '0;
            hs_p0  <= hs_c;
            vs_p0  <= vs_c;
            sof_p0 <= sof_c;
            // p1: wait for the frame buffer read to return
            req_p1 <= req_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            sof_p1 <= sof_p0;
            // p2: encoder-facing outputs, data gated by the delayed request
            vde_p2 <= req_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            sof_p2 <= sof_p1;
            rgb_p2 <= req_p1 ? rgb_src : '0;
        end
    end

    assign vid.pix_req = req_p0;
    assign vid.pix_x   = x_p0;
    assign vid.pix_y   = y_p0;
    assign vid.vde     = vde_p2;
    assign vid.hsync   = hs_p2;
    assign vid.vsync   = vs_p2;
    assign vid.sof     = sof_p2;
    assign vid.rgb_out = rgb_p2;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Scoreboard bench for dvi_timing_gen on a reduced 32x6 raster (48x12 total)
// so several frames fit in a short run.
module tb_dvi_timing_gen;

    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 48
    localparam int VT = VA + VF + VS + VB;   // 12
    localparam int FRAME = HT * VT;          // 576
    localparam int BAR_W = HA / 8;           // 4

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        int          x;
        int          y;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dvi_timing_gen_if vif ();

    dvi_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .pix_clk (clk),
        .rst     (rst),
        .vid     (vif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int x, input int y);
        logic [7:0] xb, yb;
        xb = x[7:0];
        yb = y[7:0];
`ifdef DVI_TIMING_COLORBAR_EN
        case (x / BAR_W)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return {xb, yb, 8'hA5};
`endif
    endfunction

    task automatic push_frames(input int n);
        pix_t p;
        for (int f = 0; f < n; f++)
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++) begin
                    p.x   = x;
                    p.y   = y;
                    p.rgb = exp_rgb(x, y);
                    p.sof = (x == 0 && y == 0);
                    exp_q.push_back(p);
                end
    endtask

    // Upstream frame buffer with one cycle of read latency.
    initial begin
        logic [23:0] pend;
        vif.rgb_in = 24'h0;
        forever begin
            @(negedge clk);
            pend = vif.pix_req ? {vif.pix_x[7:0], vif.pix_y[7:0], 8'hA5} : 24'h0;
            @(posedge clk);
            #1 vif.rgb_in = pend;
        end
    end

    // Monitor: pops expected pixels on vde and tracks sync/vde edge timing.
    initial begin
        int   cyc, vrise, vfall, hfall, vsfall, sof_cyc, hrise_c;
        bit   vrise_ok, vfall_ok, hfall_ok, sof_ok, vsfall_ok;
        logic pv, ph, pvs;
        pix_t p;
        cyc = 0; vrise = 0; vfall = 0; hfall = 0; vsfall = 0; sof_cyc = 0;
        vrise_ok = 0; vfall_ok = 0; hfall_ok = 0; sof_ok = 0; vsfall_ok = 0;
        pv = 1'b0; ph = 1'b1; pvs = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0;
                vrise_ok = 0; vfall_ok = 0; hfall_ok = 0; sof_ok = 0; vsfall_ok = 0;
                pv = 1'b0; ph = 1'b1; pvs = 1'b1;
            end else begin
                cyc++;
                if (vif.vde) begin
                    if (exp_q.size() == 0) begin
                        check("vde_without_expected_pixel", 32'(vif.vde), 32'h0);
                    end else begin
                        p = exp_q.pop_front();
                        check($sformatf("rgb(%0d,%0d)", p.x, p.y), 32'(vif.rgb_out), 32'(p.rgb));
                        check($sformatf("sof(%0d,%0d)", p.x, p.y), 32'(vif.sof), 32'(p.sof));
                    end
                end else begin
                    check("rgb_blank", 32'(vif.rgb_out), 32'h0);
                    check("sof_blank", 32'(vif.sof), 32'h0);
                end
                if (vif.vde && !pv) begin
                    if (vfall_ok)
                        check("vde_low_len", 32'(cyc - vfall),
                              vif.sof ? 32'((VT - VA) * HT + HT - HA) : 32'(HT - HA));
                    vrise = cyc; vrise_ok = 1;
                end
                if (!vif.vde && pv) begin
                    check("vde_high_len", 32'(cyc - vrise), 32'(HA));
                    vfall = cyc; vfall_ok = 1;
                end
                if (!vif.hsync && ph) begin
                    if (hfall_ok) check("hsync_period", 32'(cyc - hfall), 32'(HT));
                    if (vrise_ok && (cyc - vrise) < HT)
                        check("hsync_offset", 32'(cyc - vrise), 32'(HA + HF));
                    hfall = cyc; hfall_ok = 1;
                end
                if (vif.hsync && !ph && hfall_ok) begin
                    hrise_c = cyc - hfall;
                    check("hsync_width", 32'(hrise_c), 32'(HS));
                end
                if (vif.sof) begin
                    if (sof_ok) check("sof_period", 32'(cyc - sof_cyc), 32'(FRAME));
                    sof_cyc = cyc; sof_ok = 1;
                end
                if (!vif.vsync && pvs) begin
                    if (sof_ok) check("vsync_offset", 32'(cyc - sof_cyc), 32'((VA + VF) * HT));
                    vsfall = cyc; vsfall_ok = 1;
                end
                if (vif.vsync && !pvs && vsfall_ok)
                    check("vsync_width", 32'(cyc - vsfall), 32'(VS * HT));
                pv = vif.vde; ph = vif.hsync; pvs = vif.vsync;
            end
        end
    end

    task automatic release_checks(input string tag);
        @(posedge clk); #1;
        check({tag, "_e1_pix_req"}, 32'(vif.pix_req), 32'h1);
        check({tag, "_e1_pix_x"}, 32'(vif.pix_x), 32'h0);
        check({tag, "_e1_pix_y"}, 32'(vif.pix_y), 32'h0);
        check({tag, "_e1_vde"}, 32'(vif.vde), 32'h0);
        @(posedge clk); #1;
        check({tag, "_e2_vde"}, 32'(vif.vde), 32'h0);
        @(posedge clk); #1;
        check({tag, "_e3_vde"}, 32'(vif.vde), 32'h1);
        check({tag, "_e3_sof"}, 32'(vif.sof), 32'h1);
    endtask

    initial begin
        logic [23:0] px53;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_req", 32'(vif.pix_req), 32'h0);
        check("rst_pix_x", 32'(vif.pix_x), 32'h0);
        check("rst_pix_y", 32'(vif.pix_y), 32'h0);
        check("rst_vde", 32'(vif.vde), 32'h0);
        check("rst_hsync", 32'(vif.hsync), 32'h1);
        check("rst_vsync", 32'(vif.vsync), 32'h1);
        check("rst_sof", 32'(vif.sof), 32'h0);
        check("rst_rgb", 32'(vif.rgb_out), 32'h0);

        push_frames(3);
        @(posedge clk); #1 rst = 1'b0;
        release_checks("first");

        // Pixel (5,3) is raster index 3*48+5 = 149, on vde after edge 152.
`ifdef DVI_TIMING_COLORBAR_EN
        px53 = 24'hFFFF00;
`else
        px53 = 24'h0503A5;
`endif
        repeat (152 - 3) @(posedge clk);
        #1;
        check("px53_vde", 32'(vif.vde), 32'h1);
        check("px53_rgb", 32'(vif.rgb_out), 32'(px53));

        // Third frame, counters at line 2, column 10 during this cycle.
        repeat (2 * FRAME + 2 * HT + 10 - 152) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_vde", 32'(vif.vde), 32'h0);
        check("mid_rst_hsync", 32'(vif.hsync), 32'h1);
        check("mid_rst_vsync", 32'(vif.vsync), 32'h1);
        check("mid_rst_pix_req", 32'(vif.pix_req), 32'h0);
        check("mid_rst_rgb", 32'(vif.rgb_out), 32'h0);
        check("mid_rst_sof", 32'(vif.sof), 32'h0);
        exp_q.delete();
        push_frames(2);
        rst = 1'b0;
        release_checks("restart");

        repeat (FRAME + 60) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
